// File: rtl/cache_read_data_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_read_data_if
// Purpose  : CPU read port plus cache-line request/return bundle for
//            cache_read_data.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_read_data_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int WORD_WIDTH = 16
);
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

    logic                          cpu_read;
    logic [ADDR_WIDTH-1:0]         cpu_address;
    logic [1:0]                    cpu_byte_enable;
    logic [WORD_WIDTH-1:0]         cpu_rdata;
    logic                          cpu_resp;
    logic                          line_req;
    logic [ADDR_WIDTH-OFFSET_BITS-1:0] line_addr;
    logic                          line_valid;
    logic [LINE_WIDTH-1:0]         line_in;
    logic                          line_inval;

    // Environment side: the CPU and the cache array / fill logic.
    modport master (
        output cpu_read, cpu_address, cpu_byte_enable,
        output line_valid, line_in, line_inval,
        input  cpu_rdata, cpu_resp, line_req, line_addr
    );

    modport slave (
        input  cpu_read, cpu_address, cpu_byte_enable,
        input  line_valid, line_in, line_inval,
        output cpu_rdata, cpu_resp, line_req, line_addr
    );
endinterface
`default_nettype wire

// File: rtl/cache_read_data.sv
`default_nettype none
// ============================================================================
// Module   : cache_read_data
// Purpose  : Fetches the addressed cache line for a CPU read and returns the
//            byte-masked 16-bit word with a one-cycle response pulse.
//            Optional macro CACHE_RD_LINE_BUF_EN keeps the last line for
//            single-cycle hits.
// Revision : 1.0 - initial release
// ============================================================================
module cache_read_data #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int WORD_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    cache_read_data_if.slave bus
);
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int WORDS       = LINE_WIDTH / WORD_WIDTH;
    localparam int IDX_BITS    = $clog2(WORDS);
    localparam int TAG_BITS    = ADDR_WIDTH - OFFSET_BITS;
    localparam int HALF        = WORD_WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [LINE_WIDTH-1:0] line_buf;
    logic [IDX_BITS-1:0]   word_idx;
    logic [1:0]            byte_en;
    logic [TAG_BITS-1:0]   line_addr_q;
    logic [WORD_WIDTH-1:0] rdata_q;

    logic [TAG_BITS-1:0]   req_tag;
    logic [IDX_BITS-1:0]   req_idx;
    logic                  capture;
    logic                  buf_hit;
    logic                  load_req;
    logic                  load_rdata;

    assign req_tag = bus.cpu_address[ADDR_WIDTH-1:OFFSET_BITS];
    assign req_idx = bus.cpu_address[OFFSET_BITS-1:1];
    assign capture = (state == FETCH) && bus.line_valid;

    logic unused_addr_lsb;
    assign unused_addr_lsb = bus.cpu_address[0];

`ifdef CACHE_RD_LINE_BUF_EN
    logic                buf_valid;
    logic [TAG_BITS-1:0] buf_tag;

    // Invalidate has priority over a same-cycle capture so a line written
    // during its own fetch is never served stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
        end else begin
            if (capture) begin
                buf_valid <= 1'b1;
                buf_tag   <= line_addr_q;
            end
            if (bus.line_inval) begin
                buf_valid <= 1'b0;
            end
        end
    end

    assign buf_hit = buf_valid && (buf_tag == req_tag) && !bus.line_inval;
`else
    logic unused_line_inval;
    assign unused_line_inval = bus.line_inval;
    assign buf_hit           = 1'b0;
`endif

    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        load_rdata = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_read) begin
                    load_req   = 1'b1;
                    load_rdata = buf_hit;
                    state_next = buf_hit ? RESP : FETCH;
                end
            end
            FETCH: begin
                if (bus.line_valid) begin
                    load_rdata = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read data is formed on the edge that enters RESP: from the incoming
    // line on a fetch, or from the held line and live request on a hit.
    logic [LINE_WIDTH-1:0] src_line;
    logic [IDX_BITS-1:0]   src_idx;
    logic [1:0]            src_be;
    logic [WORD_WIDTH-1:0] src_words [WORDS];
    logic [WORD_WIDTH-1:0] sel_word;
    logic [WORD_WIDTH-1:0] masked_word;

    assign src_line = (state == FETCH) ? bus.line_in : line_buf;
    assign src_idx  = (state == IDLE) ? req_idx : word_idx;
    assign src_be   = (state == IDLE) ? bus.cpu_byte_enable : byte_en;

    for (genvar i = 0; i < WORDS; i++) begin : g_words
        assign src_words[i] = src_line[i*WORD_WIDTH +: WORD_WIDTH];
    end

    assign sel_word    = src_words[src_idx];
    assign masked_word = {src_be[1] ? sel_word[WORD_WIDTH-1:HALF] : {HALF{1'b0}},
                          src_be[0] ? sel_word[HALF-1:0]          : {HALF{1'b0}}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            line_buf    <= '0;
            word_idx    <= '0;
            byte_en     <= '0;
            line_addr_q <= '0;
            rdata_q     <= '0;
        end else begin
            state <= state_next;
            if (load_req) begin
                word_idx    <= req_idx;
                byte_en     <= bus.cpu_byte_enable;
                line_addr_q <= req_tag;
            end
            if (capture) begin
                line_buf <= bus.line_in;
            end
            if (load_rdata) begin
                rdata_q <= masked_word;
            end
        end
    end

    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_resp  = (state == RESP);
    assign bus.line_req  = (state == FETCH);
    assign bus.line_addr = line_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_read_data.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_read_data
// Purpose  : Directed self-checking bench for cache_read_data with a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_read_data;
`ifdef CACHE_RD_LINE_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_read_data_if #(.ADDR_WIDTH(16), .LINE_WIDTH(128), .WORD_WIDTH(16)) bus ();

    cache_read_data #(.ADDR_WIDTH(16), .LINE_WIDTH(128), .WORD_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int resp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.cpu_resp === 1'b1) resp_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word at byte offset addr within the line, each byte kept only if enabled.
    function automatic logic [15:0] pick(input logic [127:0] line, input logic [15:0] addr,
                                         input logic [1:0] be);
        logic [127:0] sh;
        int           w;
        w    = (int'(addr) % 16) / 2;
        sh   = line >> (16 * w);
        pick = 16'h0000;
        if (be[0]) pick[7:0]  = sh[7:0];
        if (be[1]) pick[15:8] = sh[15:8];
    endfunction

    // Reference model: one outstanding read, tracked as "waiting for line"
    // or "responding", plus the remembered line when the buffer is enabled.
    bit           model_live = 1'b0;
    logic [15:0]  e_rdata;
    bit           e_resp, e_req;
    logic [11:0]  e_laddr;
    logic [15:0]  m_addr;
    logic [1:0]   m_be;
    logic [127:0] m_buf;
    bit           m_valid;
    logic [11:0]  m_tag;

    always @(posedge clk) begin
        if (reset) begin
            model_live = 1'b1;
            e_rdata = '0; e_resp = 1'b0; e_req = 1'b0; e_laddr = '0;
            m_addr = '0; m_be = '0; m_buf = '0; m_valid = 1'b0; m_tag = '0;
        end else if (model_live) begin
            if (e_resp) begin
                e_resp = 1'b0;
            end else if (e_req) begin
                if (bus.line_valid) begin
                    e_req   = 1'b0;
                    e_resp  = 1'b1;
                    m_buf   = bus.line_in;
                    m_tag   = e_laddr;
                    m_valid = 1'b1;
                    e_rdata = pick(m_buf, m_addr, m_be);
                end
            end else if (bus.cpu_read) begin
                m_addr  = bus.cpu_address;
                m_be    = bus.cpu_byte_enable;
                e_laddr = m_addr[15:4];
                if (BUF_EN && m_valid && m_tag == e_laddr && !bus.line_inval) begin
                    e_resp  = 1'b1;
                    e_rdata = pick(m_buf, m_addr, m_be);
                end else begin
                    e_req = 1'b1;
                end
            end
            if (bus.line_inval) m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("rdata",     32'(bus.cpu_rdata), 32'(e_rdata));
            check("resp",      32'(bus.cpu_resp),  32'(e_resp));
            check("line_req",  32'(bus.line_req),  32'(e_req));
            check("line_addr", 32'(bus.line_addr), 32'(e_laddr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One read: line returned k cycles after line_req rises. Latency is
    // counted from the request edge to the response cycle, inclusive.
    task automatic read_txn(input logic [15:0] addr, input logic [1:0] be, input int k,
                            input logic [127:0] line, input bit inv,
                            output int lat, output bit saw_req, output logic [15:0] data);
        int n0;
        int edge_n;
        bit done;
        n0 = resp_cnt;
        bus.cpu_read        = 1'b1;
        bus.cpu_address     = addr;
        bus.cpu_byte_enable = be;
        bus.line_inval      = inv;
        tick();
        edge_n              = cyc;
        bus.cpu_read        = 1'b0;
        bus.cpu_address     = 16'($urandom);
        bus.cpu_byte_enable = 2'($urandom);
        bus.line_inval      = 1'b0;
        saw_req             = bus.line_req;
        if (saw_req) begin
            for (int i = 0; i < k; i++) tick();
            bus.line_valid = 1'b1;
            bus.line_in    = line;
            tick();
            bus.line_valid = 1'b0;
            bus.line_in    = {4{$urandom}};
        end
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus.cpu_resp === 1'b1) done = 1'b1;
            else tick();
        end
        check("resp_arrived", 32'(done), 32'd1);
        lat  = cyc + 1 - edge_n;
        data = bus.cpu_rdata;
        tick();
        check("single_pulse", 32'(resp_cnt - n0), 32'd1);
    endtask

    logic [127:0] line_a, line_b, line_c;
    int           lat;
    bit           sreq;
    logic [15:0]  d;
    int           n0;

    initial begin
        line_a = {4{32'hDEAD_0000}};
        line_a[63:48] = 16'hBEEF;
        line_b = {4{32'h0F0F_F0F0}};
        line_b[47:32] = 16'hA55A;
        for (int i = 0; i < 8; i++) line_c[16*i +: 16] = 16'h1000 + 16'(i * 16'h0111);

        // Reset held two cycles while inputs toggle randomly.
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.cpu_read        = 1'($urandom);
            bus.cpu_address     = 16'($urandom);
            bus.cpu_byte_enable = 2'($urandom);
            bus.line_valid      = 1'($urandom);
            bus.line_in         = {4{$urandom}};
            bus.line_inval      = 1'($urandom);
            tick();
        end
        check("rst_rdata", 32'(bus.cpu_rdata), 32'h0000);
        check("rst_resp",  32'(bus.cpu_resp),  32'd0);
        check("rst_req",   32'(bus.line_req),  32'd0);
        check("rst_laddr", 32'(bus.line_addr), 32'h000);
        reset = 1'b0;
        bus.cpu_read = 1'b0; bus.line_valid = 1'b0; bus.line_inval = 1'b0;
        tick();

        // Word 3 of line 0x123, full enables, line two cycles after request.
        read_txn(16'h1236, 2'b11, 2, line_a, 1'b0, lat, sreq, d);
        check("t2_data",  32'(d), 32'hBEEF);
        check("t2_lat",   32'(lat), 32'd4);
        check("t2_req",   32'(sreq), 32'd1);
        check("t2_laddr", 32'(bus.line_addr), 32'h123);

        // Byte-enable masking on word 2; invalidate forces the fetch path.
        read_txn(16'h0045, 2'b01, 0, line_b, 1'b1, lat, sreq, d);
        check("t3_be01", 32'(d), 32'h005A);
        check("t3_lat",  32'(lat), 32'd2);
        read_txn(16'h0045, 2'b10, 0, line_b, 1'b1, lat, sreq, d);
        check("t3_be10", 32'(d), 32'hA500);
        read_txn(16'h0045, 2'b00, 1, line_b, 1'b1, lat, sreq, d);
        check("t3_be00", 32'(d), 32'h0000);
        check("t3_lat3", 32'(lat), 32'd3);

        // line_valid while idle must not start anything.
        n0 = resp_cnt;
        bus.line_valid = 1'b1; bus.line_in = {4{$urandom}};
        tick();
        bus.line_valid = 1'b0;
        tick();
        check("idle_valid_ignored", 32'(resp_cnt - n0), 32'd0);

        // Buffered-line reads.
        read_txn(16'h1230, 2'b11, 1, line_c, 1'b0, lat, sreq, d);
        check("t5_w0",   32'(d), 32'h1000);
        check("t5_lat0", 32'(lat), 32'd3);
        read_txn(16'h123E, 2'b11, 0, line_c, 1'b0, lat, sreq, d);
        check("t5_w7",   32'(d), 32'h1777);
        check("t5_lat1", 32'(lat), BUF_EN ? 32'd1 : 32'd2);
        check("t5_req1", 32'(sreq), BUF_EN ? 32'd0 : 32'd1);
        bus.line_inval = 1'b1;
        tick();
        bus.line_inval = 1'b0;
        read_txn(16'h1230, 2'b11, 0, line_c, 1'b0, lat, sreq, d);
        check("t5_w0b",  32'(d), 32'h1000);
        check("t5_lat2", 32'(lat), 32'd2);
        check("t5_req2", 32'(sreq), 32'd1);
        read_txn(16'h1232, 2'b01, 0, line_c, 1'b1, lat, sreq, d);
        check("t5_inval_wins", 32'(sreq), 32'd1);
        check("t5_w1",   32'(d), 32'h0011);

        // Reset in the middle of a fetch aborts without a response.
        n0 = resp_cnt;
        bus.cpu_read = 1'b1; bus.cpu_address = 16'h0ABC; bus.cpu_byte_enable = 2'b11;
        tick();
        bus.cpu_read = 1'b0;
        check("t4_req_before", 32'(bus.line_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_req_after",  32'(bus.line_req), 32'd0);
        check("t4_resp_after", 32'(bus.cpu_resp), 32'd0);
        check("t4_laddr",      32'(bus.line_addr), 32'h000);
        bus.line_valid = 1'b1; bus.line_in = line_a;
        tick();
        bus.line_valid = 1'b0;
        tick(); tick();
        check("t4_no_resp", 32'(resp_cnt - n0), 32'd0);

        // Fresh read after the abort still works.
        read_txn(16'h0ABC, 2'b11, 0, line_c, 1'b0, lat, sreq, d);
        check("t4_after_w6", 32'(d), 32'h1666);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
